// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types, colours and phase-selection helper for the pong frame scheduler
package pong_pkg;

   typedef logic [7:0] coord_x_t;
   typedef logic [6:0] coord_y_t;
   typedef logic [2:0] colour_t;

   typedef enum logic [2:0] {
      IDLE,
      PH_START,
      PH_WAIT,
      NEXT,
      FIN
   } sched_state_t;

   typedef enum logic [1:0] {
      J_BALL,
      J_PADL,
      J_PADR
   } job_t;

   typedef enum logic {
      PH_ERASE,
      PH_DRAW
   } phase_t;

   localparam colour_t  BALL_COL_DEF = 3'b111;
   localparam colour_t  PAD_COL_DEF  = 3'b010;
   localparam colour_t  BG_COL_DEF   = 3'b000;
   localparam coord_x_t PAD_LX_DEF   = 8'd4;
   localparam coord_x_t PAD_RX_DEF   = 8'd155;

   typedef struct packed {
      logic   found;
      job_t   job;
      phase_t phase;
   } sel_t;

   // Slots run {job, phase} in order 0..5; erase slots are ineligible on a first frame.
   function automatic sel_t pick_phase(input logic [2:0] job_active,
                                       input logic       first_frame,
                                       input logic [2:0] from_slot);
      sel_t       r;
      logic [2:0] slot;
      r = '{found: 1'b0, job: J_BALL, phase: PH_ERASE};
      for (int s = 0; s < 6; s++) begin
         slot = 3'(s);
         if (!r.found && (slot >= from_slot) && job_active[slot[2:1]] &&
             (slot[0] || !first_frame)) begin
            r.found = 1'b1;
            r.job   = job_t'(slot[2:1]);
            r.phase = phase_t'(slot[0]);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/vga_port_mux.sv
// rtl/vga_port_mux.sv - routes the selected drawer's pixel stream and colour onto the VGA port
module vga_port_mux
   import pong_pkg::*;
#(
   parameter colour_t BALL_COL = BALL_COL_DEF,
   parameter colour_t PAD_COL  = PAD_COL_DEF,
   parameter colour_t BG_COL   = BG_COL_DEF
) (
   input  logic       in_wait,
   input  logic       sel_pad,
   input  logic       is_draw,
   input  logic       circ_plot,
   input  logic [7:0] circ_vx,
   input  logic [6:0] circ_vy,
   input  logic       pad_plot,
   input  logic [7:0] pad_vx,
   input  logic [6:0] pad_vy,
   input  logic [7:0] hold_x,
   input  logic [6:0] hold_y,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot
);

   always_comb begin
      vga_x      = hold_x;
      vga_y      = hold_y;
      vga_colour = BG_COL;
      vga_plot   = 1'b0;
      if (in_wait) begin
         vga_x    = sel_pad ? pad_vx : circ_vx;
         vga_y    = sel_pad ? pad_vy : circ_vy;
         vga_plot = sel_pad ? pad_plot : circ_plot;
         if (is_draw) begin
            vga_colour = sel_pad ? PAD_COL : BALL_COL;
         end
      end
   end

endmodule

// File: rtl/frame_sched.sv
// rtl/frame_sched.sv - per-frame erase/draw scheduler sharing one VGA plot port between ball and paddle drawers
module frame_sched
   import pong_pkg::*;
#(
   parameter coord_x_t PAD_LX   = PAD_LX_DEF,
   parameter coord_x_t PAD_RX   = PAD_RX_DEF,
   parameter colour_t  BALL_COL = BALL_COL_DEF,
   parameter colour_t  PAD_COL  = PAD_COL_DEF,
   parameter colour_t  BG_COL   = BG_COL_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic [7:0] ball_x,
   input  logic [6:0] ball_y,
   input  logic [6:0] padl_y,
   input  logic [6:0] padr_y,
   output logic       circ_start,
   output logic [7:0] circ_x,
   output logic [6:0] circ_y,
   input  logic       circ_done,
   input  logic       circ_plot,
   input  logic [7:0] circ_vx,
   input  logic [6:0] circ_vy,
   output logic       pad_start,
   output logic [7:0] pad_x,
   output logic [6:0] pad_y,
   input  logic       pad_done,
   input  logic       pad_plot,
   input  logic [7:0] pad_vx,
   input  logic [6:0] pad_vy,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic       overrun
);

   sched_state_t state_q, state_d;
   job_t         job_q, job_d;
   phase_t       phase_q, phase_d;
   logic         first_frame_q, first_frame_d;
   logic         busy_q, busy_d;
   logic         overrun_q, overrun_d;
   coord_x_t     nb_x_q, nb_x_d, cb_x_q, cb_x_d;
   coord_y_t     nb_y_q, nb_y_d, cb_y_q, cb_y_d;
   coord_y_t     nl_q, nl_d, cl_q, cl_d;
   coord_y_t     nr_q, nr_d, cr_q, cr_d;
   logic         circ_start_q, circ_start_d;
   coord_x_t     circ_x_q, circ_x_d;
   coord_y_t     circ_y_q, circ_y_d;
   logic         pad_start_q, pad_start_d;
   coord_x_t     pad_x_q, pad_x_d;
   coord_y_t     pad_y_q, pad_y_d;
   coord_x_t     hold_x_q, hold_x_d;
   coord_y_t     hold_y_q, hold_y_d;

   logic [2:0]   job_active;
   logic [2:0]   from_slot;
   sel_t         sel;
   logic         launch;
   logic         done_sel;
   logic         is_erase;

   always_comb begin
      state_d       = state_q;
      job_d         = job_q;
      phase_d       = phase_q;
      first_frame_d = first_frame_q;
      busy_d        = busy_q;
      overrun_d     = overrun_q;
      nb_x_d        = nb_x_q;
      nb_y_d        = nb_y_q;
      nl_d          = nl_q;
      nr_d          = nr_q;
      cb_x_d        = cb_x_q;
      cb_y_d        = cb_y_q;
      cl_d          = cl_q;
      cr_d          = cr_q;
      circ_start_d  = 1'b0;
      circ_x_d      = circ_x_q;
      circ_y_d      = circ_y_q;
      pad_start_d   = 1'b0;
      pad_x_d       = pad_x_q;
      pad_y_d       = pad_y_q;
      hold_x_d      = vga_x;
      hold_y_d      = vga_y;
      launch        = 1'b0;
      is_erase      = 1'b0;
      done_sel      = (job_q == J_BALL) ? circ_done : pad_done;

      if (state_q == IDLE && tick) begin
         nb_x_d = ball_x;
         nb_y_d = ball_y;
         nl_d   = padl_y;
         nr_d   = padr_y;
      end

      // Skip tests see the snapshot being taken this cycle when leaving IDLE.
      job_active[0] = first_frame_q || (nb_x_d != cb_x_q) || (nb_y_d != cb_y_q);
      job_active[1] = first_frame_q || (nl_d != cl_q);
      job_active[2] = first_frame_q || (nr_d != cr_q);
      from_slot     = (state_q == IDLE) ? 3'd0 : ({job_q, phase_q} + 3'd1);
      sel           = pick_phase(job_active, first_frame_q, from_slot);

      if (tick && state_q != IDLE) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (tick) begin
               busy_d = 1'b1;
               if (sel.found) launch = 1'b1;
               else           state_d = FIN;
            end
         end
         PH_START: state_d = PH_WAIT;
         PH_WAIT: begin
            if (done_sel) begin
               if (phase_q == PH_DRAW) begin
                  case (job_q)
                     J_BALL: begin
                        cb_x_d = nb_x_q;
                        cb_y_d = nb_y_q;
                     end
                     J_PADL:  cl_d = nl_q;
                     default: cr_d = nr_q;
                  endcase
               end
               state_d = NEXT;
            end
         end
         NEXT: begin
            if (sel.found) launch = 1'b1;
            else           state_d = FIN;
         end
         FIN: begin
            busy_d        = 1'b0;
            first_frame_d = 1'b0;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (launch) begin
         state_d  = PH_START;
         job_d    = sel.job;
         phase_d  = sel.phase;
         is_erase = (sel.phase == PH_ERASE);
         if (sel.job == J_BALL) begin
            circ_start_d = 1'b1;
            circ_x_d     = is_erase ? cb_x_q : nb_x_d;
            circ_y_d     = is_erase ? cb_y_q : nb_y_d;
         end else if (sel.job == J_PADL) begin
            pad_start_d = 1'b1;
            pad_x_d     = PAD_LX;
            pad_y_d     = is_erase ? cl_q : nl_d;
         end else begin
            pad_start_d = 1'b1;
            pad_x_d     = PAD_RX;
            pad_y_d     = is_erase ? cr_q : nr_d;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         job_q         <= J_BALL;
         phase_q       <= PH_ERASE;
         first_frame_q <= 1'b1;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
         nb_x_q        <= '0;
         nb_y_q        <= '0;
         nl_q          <= '0;
         nr_q          <= '0;
         cb_x_q        <= '0;
         cb_y_q        <= '0;
         cl_q          <= '0;
         cr_q          <= '0;
         circ_start_q  <= 1'b0;
         circ_x_q      <= '0;
         circ_y_q      <= '0;
         pad_start_q   <= 1'b0;
         pad_x_q       <= '0;
         pad_y_q       <= '0;
         hold_x_q      <= '0;
         hold_y_q      <= '0;
      end else begin
         state_q       <= state_d;
         job_q         <= job_d;
         phase_q       <= phase_d;
         first_frame_q <= first_frame_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
         nb_x_q        <= nb_x_d;
         nb_y_q        <= nb_y_d;
         nl_q          <= nl_d;
         nr_q          <= nr_d;
         cb_x_q        <= cb_x_d;
         cb_y_q        <= cb_y_d;
         cl_q          <= cl_d;
         cr_q          <= cr_d;
         circ_start_q  <= circ_start_d;
         circ_x_q      <= circ_x_d;
         circ_y_q      <= circ_y_d;
         pad_start_q   <= pad_start_d;
         pad_x_q       <= pad_x_d;
         pad_y_q       <= pad_y_d;
         hold_x_q      <= hold_x_d;
         hold_y_q      <= hold_y_d;
      end
   end

   vga_port_mux #(
      .BALL_COL (BALL_COL),
      .PAD_COL  (PAD_COL),
      .BG_COL   (BG_COL)
   ) u_mux (
      .in_wait    (state_q == PH_WAIT),
      .sel_pad    (job_q != J_BALL),
      .is_draw    (phase_q == PH_DRAW),
      .circ_plot  (circ_plot),
      .circ_vx    (circ_vx),
      .circ_vy    (circ_vy),
      .pad_plot   (pad_plot),
      .pad_vx     (pad_vx),
      .pad_vy     (pad_vy),
      .hold_x     (hold_x_q),
      .hold_y     (hold_y_q),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot)
   );

   assign circ_start = circ_start_q;
   assign circ_x     = circ_x_q;
   assign circ_y     = circ_y_q;
   assign pad_start  = pad_start_q;
   assign pad_x      = pad_x_q;
   assign pad_y      = pad_y_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;

endmodule
